// File: rtl/cii_cursor_writer.sv
// Write-side controller for the character table: turns keystrokes into single-cell
// writes, tracks the text cursor on a COLS x ROWS grid and performs a full-screen clear.
module cii_cursor_writer #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_vld,
  output logic       key_rdy,
  input  logic [7:0] key_ascii,
  input  logic       clr,
  output logic [6:0] char_x_we,
  output logic [4:0] char_y_we,
  output logic [7:0] ascii_we,
  output logic       we_vld,
  input  logic       we_rdy,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_CLR_WRITE = 3'd3,
    ST_CLR_WAIT  = 3'd4
  } state_e;

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);
  localparam logic [7:0] SPACE = 8'h20;

  state_e     state_q, state_d;
  logic [6:0] char_x_we_q, char_x_we_d;
  logic [4:0] char_y_we_q, char_y_we_d;
  logic [7:0] ascii_we_q, ascii_we_d;
  logic       we_vld_q, we_vld_d;
  logic [6:0] cur_x_q, cur_x_d;
  logic [4:0] cur_y_q, cur_y_d;
  logic       busy_q, busy_d;

  function automatic logic [4:0] row_inc(input logic [4:0] y);
    if (y == Y_MAX) begin
      return 5'd0;
    end else begin
      return y + 5'd1;
    end
  endfunction

  // Next-state, cursor and write-request decode
  always_comb begin
    state_d     = state_q;
    char_x_we_d = char_x_we_q;
    char_y_we_d = char_y_we_q;
    ascii_we_d  = ascii_we_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          // The address registers double as the raster fill counters.
          char_x_we_d = 7'd0;
          char_y_we_d = 5'd0;
          ascii_we_d  = SPACE;
          state_d     = ST_CLR_WRITE;
        end else if (key_vld) begin
          if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
            char_x_we_d = cur_x_q;
            char_y_we_d = cur_y_q;
            ascii_we_d  = key_ascii;
            state_d     = ST_WRITE;
            if (cur_x_q == X_MAX) begin
              cur_x_d = 7'd0;
              cur_y_d = row_inc(cur_y_q);
            end else begin
              cur_x_d = cur_x_q + 7'd1;
            end
          end else if (key_ascii == 8'h0A || key_ascii == 8'h0D) begin
            cur_x_d = 7'd0;
            cur_y_d = row_inc(cur_y_q);
          end else if (key_ascii == 8'h08) begin
            char_x_we_d = cur_x_q;
            char_y_we_d = cur_y_q;
            if (cur_x_q != 7'd0) begin
              cur_x_d     = cur_x_q - 7'd1;
              char_x_we_d = cur_x_q - 7'd1;
            end else if (cur_y_q != 5'd0) begin
              cur_x_d     = X_MAX;
              cur_y_d     = cur_y_q - 5'd1;
              char_x_we_d = X_MAX;
              char_y_we_d = cur_y_q - 5'd1;
            end else begin
              cur_x_d = cur_x_q;
            end
            ascii_we_d = SPACE;
            state_d    = ST_WRITE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (we_rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CLR_WRITE: begin
        state_d = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (we_rdy) begin
          if (char_x_we_q == X_MAX && char_y_we_q == Y_MAX) begin
            cur_x_d = 7'd0;
            cur_y_d = 5'd0;
            state_d = ST_IDLE;
          end else if (char_x_we_q == X_MAX) begin
            char_x_we_d = 7'd0;
            char_y_we_d = char_y_we_q + 5'd1;
            state_d     = ST_CLR_WRITE;
          end else begin
            char_x_we_d = char_x_we_q + 7'd1;
            state_d     = ST_CLR_WRITE;
          end
        end else begin
          state_d = ST_CLR_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    we_vld_d = (state_d == ST_WRITE) || (state_d == ST_CLR_WRITE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, cursor and write-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      char_x_we_q <= 7'd0;
      char_y_we_q <= 5'd0;
      ascii_we_q  <= 8'd0;
      we_vld_q    <= 1'b0;
      cur_x_q     <= 7'd0;
      cur_y_q     <= 5'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      char_x_we_q <= char_x_we_d;
      char_y_we_q <= char_y_we_d;
      ascii_we_q  <= ascii_we_d;
      we_vld_q    <= we_vld_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      busy_q      <= busy_d;
    end
  end

  assign key_rdy   = (state_q == ST_IDLE) && !clr;
  assign char_x_we = char_x_we_q;
  assign char_y_we = char_y_we_q;
  assign ascii_we  = ascii_we_q;
  assign we_vld    = we_vld_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cii_cursor_writer.sv
// Scoreboard bench for cii_cursor_writer: a linear-position cursor model queues the
// expected writes; a monitor pops and compares every strobe independently.
module tb_cii_cursor_writer;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_vld = 1'b0;
  logic       key_rdy;
  logic [7:0] key_ascii = 8'd0;
  logic       clr = 1'b0;
  logic [6:0] char_x_we;
  logic [4:0] char_y_we;
  logic [7:0] ascii_we;
  logic       we_vld;
  logic       we_rdy;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  cii_cursor_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .key_vld(key_vld), .key_rdy(key_rdy),
    .key_ascii(key_ascii), .clr(clr), .char_x_we(char_x_we), .char_y_we(char_y_we),
    .ascii_we(ascii_we), .we_vld(we_vld), .we_rdy(we_rdy), .cur_x(cur_x),
    .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Standard table: not ready the cycle after a strobe, ready again one cycle later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) we_rdy <= 1'b1;
    else        we_rdy <= !we_vld;
  end

  typedef struct { int x; int y; int d; } wr_t;
  wr_t exp_q[$];
  int  p = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  pops = 0;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_wr(input int pos, input int d);
    wr_t w;
    w.x = pos % COLS; w.y = pos / COLS; w.d = d;
    exp_q.push_back(w);
  endtask

  // Reference model on the linear cell index
  task automatic model_key(input logic [7:0] k, output bit wr);
    wr = 1'b0;
    if (k >= 8'h20 && k <= 8'h7E) begin
      push_wr(p, int'(k)); p = (p + 1) % CELLS; wr = 1'b1;
    end else if (k == 8'h0A || k == 8'h0D) begin
      p = ((p / COLS + 1) % ROWS) * COLS;
    end else if (k == 8'h08) begin
      if (p > 0) p = p - 1;
      push_wr(p, 32'h20); wr = 1'b1;
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && we_vld) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_x", int'(char_x_we), w.x);
        check("wr_y", int'(char_y_we), w.y);
        check("wr_d", int'(ascii_we), w.d);
      end
    end
  end

  task automatic wait_idle(input int exp_lat, input string nm);
    int lat = 1;
    while (!key_rdy && lat < 10000) begin
      @(posedge clk); #1; lat++;
    end
    check(nm, lat, exp_lat);
  endtask

  task automatic check_cursor(input string nm);
    check({nm, "_x"}, int'(cur_x), p % COLS);
    check({nm, "_y"}, int'(cur_y), p / COLS);
  endtask

  task automatic send_key(input logic [7:0] k);
    bit wr;
    @(negedge clk);
    key_vld = 1'b1; key_ascii = k;
    @(posedge clk); #1;
    key_vld = 1'b0;
    model_key(k, wr);
    check_cursor("cursor");
    wait_idle(wr ? 4 : 1, "key_lat");
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic goto_xy(input int x, input int y);
    int n = 0;
    while (p != y * COLS && n < 40) begin
      send_key(8'h0D); n++;
    end
    for (int i = 0; i < x; i++) send_key(8'h2E);
  endtask

  initial begin
    bit wr;
    int n;
    int pops_at_rst;
    logic [7:0] k;
    #23 rst_n = 1'b1;
    @(negedge clk);
    check("rst_we_vld", int'(we_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_key_rdy", int'(key_rdy), 1);
    check("rst_addr", int'(char_x_we) + int'(char_y_we) + int'(ascii_we), 0);
    check_cursor("rst_cursor");

    send_key(8'h41);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: k = 8'($urandom_range(32'h20, 32'h7E));
        6: k = ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
        7: k = 8'h08;
        8: k = 8'($urandom_range(0, 255));
        default: k = 8'h00;
      endcase
      send_key(k);
    end

    goto_xy(69, 29);
    send_key(8'h5A);
    check("wrap_to_origin", p, 0);

    goto_xy(0, 5);
    send_key(8'h08);
    check("bs_row_up", p, 4 * COLS + 69);
    goto_xy(0, 0);
    send_key(8'h08);

    goto_xy(12, 3);
    send_key(8'h0D);
    send_key(8'h00);

    // Clear with a simultaneous keystroke held by the source
    @(negedge clk);
    clr = 1'b1; key_vld = 1'b1; key_ascii = 8'h51;
    #1 check("clr_blocks_key", int'(key_rdy), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < CELLS; i++) push_wr(i, 32'h20);
    p = 0;
    check("clr_busy", int'(busy), 1);
    wait_idle(CELLS * 3 + 1, "clr_lat");
    check("clr_queue", exp_q.size(), 0);
    check_cursor("clr_cursor");
    @(posedge clk); #1;
    key_vld = 1'b0;
    model_key(8'h51, wr);
    check_cursor("held_key_cursor");
    wait_idle(4, "held_key_lat");
    check("held_key_queue", exp_q.size(), 0);

    // Reset in the middle of a clear
    send_key(8'h2B);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < CELLS; i++) push_wr(i, 32'h20);
    n = 0;
    pops_at_rst = pops + 500;
    while (pops < pops_at_rst && n < 5000) begin
      @(negedge clk); n++;
    end
    check("clr_progress", pops, pops_at_rst);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we_vld", int'(we_vld), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_addr", int'(char_x_we) + int'(char_y_we) + int'(ascii_we), 0);
    exp_q.delete();
    p = 0;
    check_cursor("arst_cursor");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pops_at_rst = pops;
    repeat (20) @(negedge clk);
    check("no_strobes_after_rst", pops, pops_at_rst);
    check("idle_after_rst", int'(key_rdy), 1);
    send_key(8'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
